i2s_rx_deser: RTL and testbench

Slave-mode I2S receiver for the DE2 audio codec ADC path. It oversamples the codec's serial bit clock, left/right clock and ADC data pins in the 50 MHz `clk_in` domain. It deserializes one left and one right sample per frame and presents both as a parallel stereo pair with a single-cycle valid strobe. It is the consumer of the LR/bit clocks our clock-divider blocks generate for the codec.

---
 rtl/i2s_rx_deser.sv | 146 ++++++++++++++
 tb/tb_i2s_rx_deser.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_deser.sv
// Slave-mode I2S receiver: oversamples bclk/lrclk/adcdat in clk_in, deserializes MSB-first words, pairs left+right.
// Outputs update together with a one-cycle sample_valid; short words raise a one-cycle frame_err.
module i2s_rx_deser #(
  parameter int DATA_W = 16
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              bclk,
  input  logic              lrclk,
  input  logic              adcdat,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              sample_valid,
  output logic              frame_err
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, HOLD} state_t;

  state_t            state, state_nx;
  logic [2:0]        bclk_sync;
  logic [1:0]        lr_sync;
  logic [1:0]        dat_sync;
  logic              lr_prev;
  logic              lr_seen;
  logic              chan;
  logic              have_left;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] left_shadow;

  logic bit_evt, lr_s, dat_s, lr_chg;
  logic start_word, shift_en, word_done, short_word;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      dat_sync  <= '0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], bclk};
      lr_sync   <= {lr_sync[0], lrclk};
      dat_sync  <= {dat_sync[0], adcdat};
    end
  end

  assign bit_evt = bclk_sync[1] & ~bclk_sync[2];
  assign lr_s    = lr_sync[1];
  assign dat_s   = dat_sync[1];
  // No LR change can be declared until one lrclk sample exists after reset.
  assign lr_chg  = bit_evt & lr_seen & (lr_s != lr_prev);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      lr_prev <= 1'b0;
      lr_seen <= 1'b0;
    end else if (bit_evt) begin
      lr_prev <= lr_s;
      lr_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    start_word = 1'b0;
    shift_en   = 1'b0;
    word_done  = 1'b0;
    short_word = 1'b0;
    case (state)
      IDLE: begin
        if (lr_chg) begin
          start_word = 1'b1;
          state_nx   = SKIP;
        end
      end
      SKIP: state_nx = SHIFT;
      SHIFT: begin
        if (lr_chg) begin
          short_word = 1'b1;
          start_word = 1'b1;
          state_nx   = SKIP;
        end else if (bit_evt) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) state_nx = HOLD;
        end
      end
      HOLD: begin
        if (lr_chg) begin
          word_done  = 1'b1;
          start_word = 1'b1;
          state_nx   = SKIP;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      chan         <= 1'b0;
      bit_cnt      <= '0;
      shreg        <= '0;
      left_shadow  <= '0;
      have_left    <= 1'b0;
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (start_word) begin
        chan    <= lr_s;
        bit_cnt <= '0;
      end
      if (shift_en) begin
        shreg   <= {shreg[DATA_W-2:0], dat_s};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (short_word) begin
        have_left <= 1'b0;
        frame_err <= 1'b1;
      end
      if (word_done) begin
        if (!chan) begin
          left_shadow <= shreg;
          have_left   <= 1'b1;
        end else if (have_left) begin
          // A right word only publishes when a left word precedes it.
          left_data    <= left_shadow;
          right_data   <= shreg;
          sample_valid <= 1'b1;
          have_left    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Bench for i2s_rx_deser: drives I2S bit streams, predicts word-level results, checks every cycle.
module tb_i2s_rx_deser;
  localparam int W = 16;

  logic         clk_in = 1'b0;
  logic         rst_n  = 1'b0;
  logic         bclk   = 1'b0;
  logic         lrclk  = 1'b0;
  logic         adcdat = 1'b0;
  logic [W-1:0] left_data, right_data;
  logic         sample_valid, frame_err;

  always #10 clk_in = ~clk_in;

  i2s_rx_deser #(.DATA_W(W)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .bclk(bclk), .lrclk(lrclk), .adcdat(adcdat),
    .left_data(left_data), .right_data(right_data),
    .sample_valid(sample_valid), .frame_err(frame_err)
  );

  typedef struct {
    bit           is_pair;
    logic [W-1:0] l;
    logic [W-1:0] r;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, errors = 0;
  int   half = 4;
  int   n_valid = 0, n_err = 0;

  // Word-level model of the link.
  bit          lr_known = 0, last_lr = 0, capturing = 0, have_left = 0;
  logic [W-1:0] shadow = '0;
  bit          pend_chan = 0;
  int          pend_len = 0, pend_vb = W;
  logic [31:0] pend_src = '0;

  logic [W-1:0] cur_l = '0, cur_r = '0;
  bit           prev_vld = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  function automatic logic [W-1:0] top_bits(input logic [31:0] v, input int vb);
    if (vb >= W) return W'(v >> (vb - W));
    else         return W'(v << (W - vb));
  endfunction

  task automatic model_complete();
    exp_t e;
    if (pend_len < W) begin
      e.is_pair = 0; e.l = '0; e.r = '0;
      exp_q.push_back(e);
      have_left = 0;
    end else if (!pend_chan) begin
      shadow    = top_bits(pend_src, pend_vb);
      have_left = 1;
    end else if (have_left) begin
      e.is_pair = 1; e.l = shadow; e.r = top_bits(pend_src, pend_vb);
      exp_q.push_back(e);
      have_left = 0;
    end
  endtask

  task automatic send_bit(input bit lr, input bit d);
    bclk = 1'b0; lrclk = lr; adcdat = d;
    repeat (half) @(posedge clk_in);
    #1 bclk = 1'b1;
    repeat (half) @(posedge clk_in);
    #1;
  endtask

  // First bit of a slot; its data bit (1) is the previous word's trailing bit.
  task automatic change_bit(input bit c);
    if (lr_known && c != last_lr) begin
      if (capturing) model_complete();
      capturing = 1; pend_chan = c; pend_len = 0; pend_src = '0; pend_vb = W;
    end
    lr_known = 1; last_lr = c;
    send_bit(c, 1'b1);
  endtask

  task automatic data_bits(input logic [31:0] v, input int vb, input int n);
    bit b;
    if (capturing) begin pend_src = v; pend_vb = vb; end
    for (int i = 0; i < n; i++) begin
      b = (i < vb) ? v[vb-1-i] : 1'b0;
      send_bit(last_lr, b);
      lr_known = 1;
      if (capturing) pend_len++;
    end
  endtask

  task automatic do_reset();
    bclk = 1'b0;
    repeat (4) @(posedge clk_in);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_left", 32'(left_data), 0);
    chk("rst_right", 32'(right_data), 0);
    chk("rst_valid", 32'(sample_valid), 0);
    chk("rst_err", 32'(frame_err), 0);
    lr_known = 0; capturing = 0; have_left = 0;
    exp_q.delete();
    repeat (2) @(posedge clk_in);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk_in);
  endtask

  task automatic checkpoint(input string name, input logic [W-1:0] l, input logic [W-1:0] r,
                            input int nv, input int ne);
    repeat (8) @(posedge clk_in);
    #1;
    chk({name, "_left"}, 32'(left_data), 32'(l));
    chk({name, "_right"}, 32'(right_data), 32'(r));
    chk({name, "_nvalid"}, 32'(n_valid), 32'(nv));
    chk({name, "_nerr"}, 32'(n_err), 32'(ne));
    chk({name, "_drained"}, 32'(exp_q.size()), 0);
  endtask

  always @(negedge clk_in) begin
    if (!rst_n) begin
      cur_l = '0; cur_r = '0; prev_vld = 0;
    end else begin
      if (sample_valid) begin
        n_valid++;
        chk("valid_not_back_to_back", 32'(prev_vld), 0);
        if (exp_q.size() == 0 || !exp_q[0].is_pair) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got pair %h/%h expected none", left_data, right_data);
        end else begin
          chk("pair_left", 32'(left_data), 32'(exp_q[0].l));
          chk("pair_right", 32'(right_data), 32'(exp_q[0].r));
          cur_l = exp_q[0].l; cur_r = exp_q[0].r;
          void'(exp_q.pop_front());
        end
      end else begin
        chk("hold_left", 32'(left_data), 32'(cur_l));
        chk("hold_right", 32'(right_data), 32'(cur_r));
      end
      if (frame_err) begin
        n_err++;
        if (exp_q.size() == 0 || exp_q[0].is_pair) begin
          checks++; errors++;
          $display("FAIL unexpected_frame_err: got 1 expected 0");
        end else begin
          checks++;
          void'(exp_q.pop_front());
        end
      end
      prev_vld = sample_valid;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // 64fs-style slots, slower bclk.
    half = 8;
    change_bit(1'b1);
    change_bit(1'b0);
    data_bits(32'hA5C3, 16, 31); change_bit(1'b1);
    data_bits(32'h1234, 16, 31); change_bit(1'b0);
    checkpoint("fs64", 16'hA5C3, 16'h1234, 1, 0);

    // Exact-length words, back to back.
    half = 4;
    data_bits(32'h0001, 16, 16); change_bit(1'b1);
    data_bits(32'h8000, 16, 16); change_bit(1'b0);
    checkpoint("exact1", 16'h0001, 16'h8000, 2, 0);
    data_bits(32'hFFFF, 16, 16); change_bit(1'b1);
    data_bits(32'h0000, 16, 16); change_bit(1'b0);
    checkpoint("exact2", 16'hFFFF, 16'h0000, 3, 0);
    data_bits(32'h7FFE, 16, 16); change_bit(1'b1);
    data_bits(32'h4001, 16, 16); change_bit(1'b0);
    checkpoint("exact3", 16'h7FFE, 16'h4001, 4, 0);

    // Short left word.
    data_bits(32'h5555, 16, 10); change_bit(1'b1);
    checkpoint("short_err", 16'h7FFE, 16'h4001, 4, 1);
    data_bits(32'h3333, 16, 16); change_bit(1'b0);
    checkpoint("short_orphan", 16'h7FFE, 16'h4001, 4, 1);
    data_bits(32'hCAFE, 16, 16); change_bit(1'b1);
    data_bits(32'hBEEF, 16, 16); change_bit(1'b0);
    checkpoint("short_recover", 16'hCAFE, 16'hBEEF, 5, 1);

    // 24-bit words truncate to the upper bits.
    data_bits(32'hABCDEF, 24, 24); change_bit(1'b1);
    data_bits(32'h123456, 24, 24); change_bit(1'b0);
    checkpoint("w24", 16'hABCD, 16'h1234, 6, 1);

    // Reset in the middle of a right word.
    data_bits(32'h9999, 16, 16); change_bit(1'b1);
    data_bits(32'h7777, 16, 6);
    do_reset();
    data_bits(32'h7777, 16, 5);
    change_bit(1'b0);
    data_bits(32'h1111, 16, 16); change_bit(1'b1);
    data_bits(32'h2222, 16, 16); change_bit(1'b0);
    checkpoint("rst_mid", 16'h1111, 16'h2222, 7, 1);

    // Release reset while lrclk is high, mid right word.
    last_lr = 1'b1; lrclk = 1'b1;
    do_reset();
    data_bits(32'h5A5A, 16, 7);
    change_bit(1'b0);
    data_bits(32'h4242, 16, 16); change_bit(1'b1);
    checkpoint("right_start_wait", 16'h0000, 16'h0000, 7, 1);
    data_bits(32'h2424, 16, 16); change_bit(1'b0);
    checkpoint("right_start", 16'h4242, 16'h2424, 8, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
